// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types, encodings and byte-order helpers for sram_arbiter.
// Optional feature macro used by the arbiter: SRAM_ARB_FETCH_BUF_EN.
package sram_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Port that owns (or last owned) the SRAM
    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Core-side access size (d_size)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // spi_master transfer length (spi_byte_mask)
    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    function automatic logic [1:0] size_to_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return MASK_BYTE;
            SIZE_HALF: return MASK_HALF;
            default:   return MASK_WORD;
        endcase
    endfunction

    // Little-endian core word <-> first-byte-in-MSB serial word
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // The first byte shifted in from the SRAM lands in o[31:24]; return it
    // as an LSB-aligned, zero-extended little-endian value.
    function automatic logic [31:0] read_extract(input logic [1:0] mask, input logic [31:0] o);
        case (mask)
            MASK_BYTE: return {24'b0, o[31:24]};
            MASK_HALF: return {16'b0, o[23:16], o[31:24]};
            default:   return bswap32(o);
        endcase
    endfunction

endpackage

// File: rtl/sram_fetch_buf.sv
// sram_fetch_buf: single-entry instruction word buffer (tag, data, valid).
// Hits only on word-aligned lookups; an invalidate in the same cycle wins.
module sram_fetch_buf #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              fill_en,
    input  logic [ADDR_W-3:0] fill_tag,
    input  logic [31:0]       fill_data,
    input  logic              inv_en,
    input  logic [ADDR_W-3:0] inv_first_tag,
    input  logic [ADDR_W-3:0] inv_last_tag,
    output logic              tag_hit,
    output logic              hit,
    output logic [31:0]       rdata
);

    logic              valid_q;
    logic [ADDR_W-3:0] tag_q;
    logic [31:0]       data_q;
    logic              inv_match;

    assign inv_match = inv_en && valid_q &&
                       ((inv_first_tag == tag_q) || (inv_last_tag == tag_q));
    assign tag_hit   = lookup_en && valid_q && (lookup_addr[1:0] == 2'b00) &&
                       (lookup_addr[ADDR_W-1:2] == tag_q);
    assign hit       = tag_hit && !inv_match;
    assign rdata     = data_q;

    // Valid bit: set on fill, cleared by an overlapping write grant
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end else if (inv_match) begin
            valid_q <= 1'b0;
        end
    end

    // Tag and data storage, written on every aligned fetch completion
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; valid_q alone qualifies it.
        if (fill_en) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SPI SRAM between the fetch and load/store ports,
// one spi_master transaction per grant, with byte-order conversion.
// Define SRAM_ARB_FETCH_BUF_EN to add a single-entry fetch buffer.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              spi_req,
    output logic [ADDR_W-1:0] spi_addr,
    output logic [31:0]       spi_data_in,
    output logic [1:0]        spi_byte_mask,
    output logic              spi_write,
    input  logic [31:0]       spi_data_out,
    input  logic              spi_busy,
    input  logic              spi_valid
);

    state_t            state_q;
    grant_t            last_grant_q;
    logic              if_ack_q, d_ack_q;
    logic [31:0]       if_rdata_q, d_rdata_q;
    logic              spi_req_q, spi_write_q;
    logic [ADDR_W-1:0] spi_addr_q;
    logic [31:0]       spi_data_in_q;
    logic [1:0]        spi_mask_q;

    logic   if_pend, d_pend, grant_any;
    grant_t grant_sel;

    // A request still high during its own ack cycle is already served.
    assign d_pend = d_req && !d_ack_q;

`ifdef SRAM_ARB_FETCH_BUF_EN
    logic              buf_tag_hit, buf_hit;
    logic [31:0]       buf_rdata;
    logic              buf_lookup, buf_fill, buf_inv;
    logic [1:0]        d_last_off;
    logic [ADDR_W-1:0] d_last_addr;

    // Never look up a fetch that is itself in flight to the SRAM.
    assign buf_lookup  = if_req && !if_ack_q &&
                         !((state_q != ST_IDLE) && (last_grant_q == GNT_FETCH));
    assign buf_fill    = (state_q == ST_RUN) && spi_valid &&
                         (last_grant_q == GNT_FETCH) && (spi_addr_q[1:0] == 2'b00);
    assign buf_inv     = (state_q == ST_IDLE) && grant_any && !spi_busy &&
                         (grant_sel == GNT_DATA) && d_we;
    assign d_last_addr = d_addr + {{(ADDR_W-2){1'b0}}, d_last_off};

    // Offset of the last byte touched by a data write
    always_comb begin
        // NOTE: default first so every path assigns; otherwise a latch is inferred.
        d_last_off = 2'd3;
        case (d_size)
            SIZE_BYTE: d_last_off = 2'd0;
            SIZE_HALF: d_last_off = 2'd1;
            default:   d_last_off = 2'd3;
        endcase
    end

    sram_fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
        .clk           (clk),
        .reset         (reset),
        .lookup_en     (buf_lookup),
        .lookup_addr   (if_addr),
        .fill_en       (buf_fill),
        .fill_tag      (spi_addr_q[ADDR_W-1:2]),
        .fill_data     (bswap32(spi_data_out)),
        .inv_en        (buf_inv),
        .inv_first_tag (d_addr[ADDR_W-1:2]),
        .inv_last_tag  (d_last_addr[ADDR_W-1:2]),
        .tag_hit       (buf_tag_hit),
        .hit           (buf_hit),
        .rdata         (buf_rdata)
    );

    // Buffer-served fetches are never arbitrated.
    assign if_pend = if_req && !if_ack_q && !buf_tag_hit;
`else
    assign if_pend = if_req && !if_ack_q;
`endif

    assign grant_any = if_pend || d_pend;

    // Data wins ties unless it also won last time and fetch is waiting
    always_comb begin
        grant_sel = GNT_DATA;
        if (if_pend && (!d_pend || (last_grant_q == GNT_DATA))) begin
            grant_sel = GNT_FETCH;
        end
    end

    // Sequencer FSM with registered spi_* and ack/rdata outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_FETCH;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= 32'b0;
            d_rdata_q     <= 32'b0;
            spi_req_q     <= 1'b1;
            spi_addr_q    <= '0;
            spi_data_in_q <= 32'b0;
            spi_mask_q    <= MASK_WORD;
            spi_write_q   <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    spi_req_q <= 1'b1;
                    if (grant_any && !spi_busy) begin
                        last_grant_q <= grant_sel;
                        spi_req_q    <= 1'b0;
                        state_q      <= ST_RUN;
                        if (grant_sel == GNT_FETCH) begin
                            spi_addr_q  <= if_addr;
                            spi_write_q <= 1'b0;
                            spi_mask_q  <= MASK_WORD;
                        end else begin
                            spi_addr_q    <= d_addr;
                            spi_write_q   <= d_we;
                            spi_mask_q    <= size_to_mask(d_size);
                            spi_data_in_q <= bswap32(d_wdata);
                        end
                    end
                end
                ST_RUN: begin
                    if (spi_valid) begin
                        spi_req_q <= 1'b1;
                        state_q   <= ST_RELEASE;
                        if (last_grant_q == GNT_FETCH) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bswap32(spi_data_out);
                        end else begin
                            d_ack_q <= 1'b1;
                            if (!spi_write_q) begin
                                d_rdata_q <= read_extract(spi_mask_q, spi_data_out);
                            end
                        end
                    end
                end
                ST_RELEASE: begin
                    spi_req_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    spi_req_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
`ifdef SRAM_ARB_FETCH_BUF_EN
            if (buf_hit) begin
                if_ack_q   <= 1'b1;
                if_rdata_q <= buf_rdata;
            end
`endif
        end
    end

    assign if_ack        = if_ack_q;
    assign if_rdata      = if_rdata_q;
    assign d_ack         = d_ack_q;
    assign d_rdata       = d_rdata_q;
    assign spi_req       = spi_req_q;
    assign spi_addr      = spi_addr_q;
    assign spi_data_in   = spi_data_in_q;
    assign spi_byte_mask = spi_mask_q;
    assign spi_write     = spi_write_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a behavioural
// spi_master + SPI SRAM model. Buffer checks compile under SRAM_ARB_FETCH_BUF_EN.
module tb_sram_arbiter;

    localparam int LAT = 6;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [23:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        spi_req;
    logic [23:0] spi_addr;
    logic [31:0] spi_data_in;
    logic [1:0]  spi_byte_mask;
    logic        spi_write;
    logic [31:0] spi_data_out;
    logic        spi_busy;
    logic        spi_valid;

    int vectors     = 0;
    int miscompares = 0;
    int if_ack_cnt  = 0;
    int m_xfers     = 0;

    sram_arbiter #(.ADDR_W(24)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .if_rdata      (if_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_size        (d_size),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_ack         (d_ack),
        .d_rdata       (d_rdata),
        .spi_req       (spi_req),
        .spi_addr      (spi_addr),
        .spi_data_in   (spi_data_in),
        .spi_byte_mask (spi_byte_mask),
        .spi_write     (spi_write),
        .spi_data_out  (spi_data_out),
        .spi_busy      (spi_busy),
        .spi_valid     (spi_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- spi_master + SRAM model ----------------
    logic [7:0]  mem [0:1023];
    logic        preloaded = 1'b0;
    int          m_cnt     = 0;
    logic [23:0] m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_mask;
    logic        m_write;

    function automatic int nbytes(input logic [1:0] mask);
        if (mask == 2'b00) return 1;
        if (mask == 2'b01) return 2;
        return 4;
    endfunction

    // First byte read lands in [31:24]; unused low bytes are filler 0xEE.
    function automatic logic [31:0] sram_read(input logic [23:0] a, input int n);
        logic [31:0] o;
        logic [9:0]  idx;
        o = 32'hEEEE_EEEE;
        for (int k = 0; k < n; k++) begin
            idx = a[9:0] + 10'(k);
            o[31-8*k -: 8] = mem[idx];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            preloaded  <= 1'b1;
            mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22; mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
            mem[10'h104] <= 8'h55; mem[10'h105] <= 8'h66; mem[10'h106] <= 8'h77; mem[10'h107] <= 8'h88;
            mem[10'h010] <= 8'hCD; mem[10'h011] <= 8'hAB;
            mem[10'h040] <= 8'h01; mem[10'h041] <= 8'h02; mem[10'h042] <= 8'h03; mem[10'h043] <= 8'h04;
        end
        if (spi_req) begin
            spi_busy  <= 1'b0;
            spi_valid <= 1'b0;
            m_cnt     <= 0;
        end else if (!spi_busy && !spi_valid) begin
            spi_busy <= 1'b1;
            m_cnt    <= LAT;
            m_addr   <= spi_addr;
            m_data   <= spi_data_in;
            m_mask   <= spi_byte_mask;
            m_write  <= spi_write;
            m_xfers  <= m_xfers + 1;
        end else if (spi_busy) begin
            if (m_cnt == 0) begin
                spi_busy  <= 1'b0;
                spi_valid <= 1'b1;
                if (m_write) begin
                    for (int k = 0; k < nbytes(m_mask); k++) begin
                        mem[m_addr[9:0] + 10'(k)] <= m_data[31-8*k -: 8];
                    end
                end else begin
                    spi_data_out <= sram_read(m_addr, nbytes(m_mask));
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    initial begin
        spi_busy     = 1'b0;
        spi_valid    = 1'b0;
        spi_data_out = 32'b0;
    end

    always @(posedge clk) begin
        if (if_ack === 1'b1) if_ack_cnt <= if_ack_cnt + 1;
    end

    // Safety net in case a bounded wait is itself broken
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        do begin tick(); n++; end while (spi_req !== 1'b0 && n < 64);
        check({tag, "_grant"}, 32'(spi_req), 32'd0);
    endtask

    task automatic wait_if_ack(input string tag);
        int n = 0;
        do begin tick(); n++; end while (if_ack !== 1'b1 && n < 64);
        check({tag, "_if_ack"}, 32'(if_ack), 32'd1);
    endtask

    task automatic wait_d_ack(input string tag);
        int n = 0;
        do begin tick(); n++; end while (d_ack !== 1'b1 && n < 64);
        check({tag, "_d_ack"}, 32'(d_ack), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int acks0;
        int xfers0;
        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = 24'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 2'b00;
        d_addr  = 24'h0;
        d_wdata = 32'h0;
        repeat (3) tick();

        // Reset values
        check("rst_if_ack",    32'(if_ack),        32'd0);
        check("rst_d_ack",     32'(d_ack),         32'd0);
        check("rst_if_rdata",  if_rdata,           32'd0);
        check("rst_d_rdata",   d_rdata,            32'd0);
        check("rst_spi_req",   32'(spi_req),       32'd1);
        check("rst_spi_addr",  32'(spi_addr),      32'd0);
        check("rst_spi_din",   spi_data_in,        32'd0);
        check("rst_spi_mask",  32'(spi_byte_mask), 32'd2);
        check("rst_spi_write", 32'(spi_write),     32'd0);
        reset = 1'b1;
        tick();

        // Contention round 1: first tie after reset goes to data
        if_addr = 24'h000100;
        d_addr  = 24'h000010; d_size = 2'b01; d_we = 1'b0;
        if_req  = 1'b1; d_req = 1'b1;
        tick();
        check("r1_grant_latency", 32'(spi_req),       32'd0);
        check("r1_data_first",    32'(spi_addr),      32'h10);
        check("r1_half_mask",     32'(spi_byte_mask), 32'd1);
        wait_d_ack("r1");
        check("r1_half_rdata",    d_rdata,            32'h0000ABCD);
        d_req = 1'b0;
        wait_grant("r1_fetch");
        check("r1_fetch_addr",    32'(spi_addr),      32'h100);
        check("r1_fetch_mask",    32'(spi_byte_mask), 32'd2);
        check("r1_fetch_write",   32'(spi_write),     32'd0);
        wait_if_ack("r1");
        check("r1_fetch_rdata",   if_rdata,           32'h44332211);
        if_req = 1'b0;
        tick();

        // Contention round 2: data, then fetch, then data again
        if_addr = 24'h000104;
        if_req  = 1'b1; d_req = 1'b1;
        tick();
        check("r2_data_after_fetch", 32'(spi_addr), 32'h10);
        wait_d_ack("r2a");
        check("r2_half_rdata", d_rdata, 32'h0000ABCD);
        d_addr = 24'h000011; d_size = 2'b00;
        wait_grant("r2_fetch");
        check("r2_fetch_after_data", 32'(spi_addr), 32'h104);
        wait_if_ack("r2");
        check("r2_fetch_rdata", if_rdata, 32'h88776655);
        if_req = 1'b0;
        wait_grant("r2_data");
        check("r2_byte_addr", 32'(spi_addr),      32'h11);
        check("r2_byte_mask", 32'(spi_byte_mask), 32'd0);
        wait_d_ack("r2b");
        check("r2_byte_rdata", d_rdata, 32'h000000AB);
        d_req = 1'b0;
        tick();

        // Half read: exactly RELEASE + IDLE between transactions
        d_addr = 24'h000010; d_size = 2'b01; d_req = 1'b1;
        wait_grant("c");
        wait_d_ack("c");
        check("c_half_rdata",      d_rdata,       32'h0000ABCD);
        check("c_release_spi_req", 32'(spi_req),  32'd1);
        tick();
        check("c_idle_spi_req",    32'(spi_req),  32'd1);
        check("c_single_ack",      32'(d_ack),    32'd0);
        tick();
        check("c_regrant",         32'(spi_req),  32'd0);
        wait_d_ack("c2");
        d_req = 1'b0;

        // Byte write then byte read back
        d_addr = 24'h000203; d_size = 2'b00; d_we = 1'b1; d_wdata = 32'h000000AB;
        d_req  = 1'b1;
        wait_grant("d_wr");
        check("d_wr_swap",  spi_data_in,         32'hAB000000);
        check("d_wr_mask",  32'(spi_byte_mask),  32'd0);
        check("d_wr_write", 32'(spi_write),      32'd1);
        check("d_wr_addr",  32'(spi_addr),       32'h203);
        wait_d_ack("d_wr");
        check("d_wr_rdata_held", d_rdata, 32'h0000ABCD);
        d_we = 1'b0;
        wait_grant("d_rd");
        check("d_rd_write", 32'(spi_write), 32'd0);
        wait_d_ack("d_rd");
        check("d_rd_rdata", d_rdata, 32'h000000AB);
        d_req = 1'b0;
        tick();

        // Reset low mid-RUN drops the transaction; re-request completes
        if_addr = 24'h000100; if_req = 1'b1;
        wait_grant("f");
        tick(); tick();
        acks0 = if_ack_cnt;
        reset = 1'b0;
        tick();
        check("f_rst_spi_req", 32'(spi_req), 32'd1);
        check("f_rst_no_ack",  32'(if_ack),  32'd0);
        reset = 1'b1; if_req = 1'b0;
        tick();
        check("f_idle_spi_req", 32'(spi_req), 32'd1);
        tick(); tick();
        check("f_no_ack_after_abort", 32'(if_ack_cnt - acks0), 32'd0);
        if_req = 1'b1;
        wait_grant("f_re");
        wait_if_ack("f_re");
        check("f_re_rdata", if_rdata, 32'h44332211);
        if_req = 1'b0;
        repeat (3) tick();
        check("f_single_ack", 32'(if_ack_cnt - acks0), 32'd1);

`ifdef SRAM_ARB_FETCH_BUF_EN
        // Fetch buffer: repeat hit, then write-invalidate
        if_addr = 24'h000040; if_req = 1'b1;
        wait_grant("g1");
        wait_if_ack("g1");
        check("g1_rdata", if_rdata, 32'h04030201);
        if_req = 1'b0;
        repeat (3) tick();
        xfers0 = m_xfers;
        if_req = 1'b1;
        tick();
        check("g2_hit_ack",     32'(if_ack),  32'd1);
        check("g2_hit_spi_req", 32'(spi_req), 32'd1);
        check("g2_hit_rdata",   if_rdata,     32'h04030201);
        if_req = 1'b0;
        tick();
        check("g2_no_xfer", 32'(m_xfers - xfers0), 32'd0);
        d_addr = 24'h000040; d_size = 2'b10; d_we = 1'b1; d_wdata = 32'hCAFEF00D;
        d_req  = 1'b1;
        wait_grant("g3_wr");
        wait_d_ack("g3_wr");
        d_req = 1'b0; d_we = 1'b0;
        tick();
        if_req = 1'b1;
        wait_grant("g4_miss");
        check("g4_addr", 32'(spi_addr), 32'h40);
        wait_if_ack("g4");
        check("g4_new_data", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0;
        tick();
`else
        xfers0 = m_xfers;
        check("xfers_seen", 32'(xfers0 > 0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
